ram_arbiter: RTL

//  Shares the single 64-bit byte-enabled data RAM between instruction fetch (IF, read-only)
//  and the load/store stage (MEM, read/write). Grants one request per cycle with fair

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared widths and encodings for the IF/MEM data-RAM arbiter.
// The state and owner enums are imported by ram_arbiter.
package ram_arbiter_pkg;

   localparam int XLEN = 64;
   localparam int BE_W = 8;
   localparam int LAT_W = 3;

   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_RD_WAIT = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 64-bit byte-enabled RAM between IF (reads) and MEM
// (reads/writes); one read is outstanding at a time, and its data is routed back to the owner.
//
// state       | meaning
// ARB_IDLE    | grants accepted; a write stays here, a read moves to ARB_RD_WAIT
// ARB_RD_WAIT | read in flight; lat_cnt counts down, rvalid to the owner when lat_cnt==1
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [XLEN-1:0] if_rdata_o,
   input  logic            mem_req_i,
   input  logic            mem_wen_i,
   input  logic [BE_W-1:0] mem_byte_en_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic [XLEN-1:0] mem_wdata_i,
   output logic            mem_gnt_o,
   output logic            mem_rvalid_o,
   output logic [XLEN-1:0] mem_rdata_o,
   output logic [XLEN-1:0] ram_addr_o,
   output logic            ram_ren_o,
   output logic            ram_wen_o,
   output logic [BE_W-1:0] ram_byte_en_o,
   output logic [XLEN-1:0] ram_wdata_o,
   input  logic [XLEN-1:0] ram_rdata_i
);

   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   owner_t           r_owner;
   owner_t           w_owner_nxt;
   owner_t           r_prio;
   owner_t           w_prio_nxt;
   logic [LAT_W-1:0] r_lat_cnt;
   logic [LAT_W-1:0] w_lat_cnt_nxt;
   logic             w_if_win;
   logic             w_mem_win;
   logic             w_unused_addr_lsb;

   // RAM is doubleword-addressed; the byte offset is consumed in mem.
   assign w_unused_addr_lsb = ^{if_addr_i[2:0], mem_addr_i[2:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ARB_IDLE;
         r_owner   <= OWN_IF;
         r_prio    <= OWN_MEM;
         r_lat_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_owner   <= w_owner_nxt;
         r_prio    <= w_prio_nxt;
         r_lat_cnt <= w_lat_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_prio_nxt    = r_prio;
      w_lat_cnt_nxt = r_lat_cnt;
      w_if_win      = 1'b0;
      w_mem_win     = 1'b0;
      if_gnt_o      = 1'b0;
      if_rvalid_o   = 1'b0;
      if_rdata_o    = '0;
      mem_gnt_o     = 1'b0;
      mem_rvalid_o  = 1'b0;
      mem_rdata_o   = '0;
      ram_addr_o    = '0;
      ram_ren_o     = 1'b0;
      ram_wen_o     = 1'b0;
      ram_byte_en_o = '0;
      ram_wdata_o   = '0;

      // Grants are combinational from the request inputs, so they are masked during reset.
      if (!rst) begin
         unique case (r_state)
            ARB_IDLE: begin
               if (if_req_i && mem_req_i) begin
                  w_if_win   = (r_prio == OWN_IF);
                  w_mem_win  = (r_prio == OWN_MEM);
                  w_prio_nxt = (r_prio == OWN_IF) ? OWN_MEM : OWN_IF;
               end else begin
                  w_if_win  = if_req_i;
                  w_mem_win = mem_req_i;
               end

               if (w_if_win) begin
                  if_gnt_o      = 1'b1;
                  ram_addr_o    = {if_addr_i[XLEN-1:3], 3'b000};
                  ram_ren_o     = 1'b1;
                  w_owner_nxt   = OWN_IF;
                  w_lat_cnt_nxt = LAT_INIT;
                  w_state_nxt   = ARB_RD_WAIT;
               end else if (w_mem_win) begin
                  mem_gnt_o  = 1'b1;
                  ram_addr_o = {mem_addr_i[XLEN-1:3], 3'b000};
                  if (mem_wen_i) begin
                     ram_wen_o     = 1'b1;
                     ram_byte_en_o = mem_byte_en_i;
                     ram_wdata_o   = mem_wdata_i;
                  end else begin
                     ram_ren_o     = 1'b1;
                     w_owner_nxt   = OWN_MEM;
                     w_lat_cnt_nxt = LAT_INIT;
                     w_state_nxt   = ARB_RD_WAIT;
                  end
               end
            end

            ARB_RD_WAIT: begin
               w_lat_cnt_nxt = r_lat_cnt - 1'b1;
               // <= guards against a zero count hanging the arbiter.
               if (r_lat_cnt <= LAT_W'(1)) begin
                  w_lat_cnt_nxt = '0;
                  w_state_nxt   = ARB_IDLE;
                  if (r_owner == OWN_IF) begin
                     if_rvalid_o = 1'b1;
                     if_rdata_o  = ram_rdata_i;
                  end else begin
                     mem_rvalid_o = 1'b1;
                     mem_rdata_o  = ram_rdata_i;
                  end
               end
            end

            default: begin
               w_state_nxt = ARB_IDLE;
            end
         endcase
      end
   end

endmodule
